// File: rtl/util_sync_filter.sv
// Per-bit debounce filter for synchronized levels with rise/fall pulses and sticky event flags.
// Optional saturating event counter compiled in with UTIL_SYNC_FILTER_CNT_EN.
module util_sync_filter #(
    parameter int               WIDTH         = 1,
    parameter int               STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] INIT_VAL      = '0,
    parameter int               CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] evt_flag,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int            CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CW-1:0]    cnt_q   [WIDTH];
    logic [CW-1:0]    cnt_d   [WIDTH];
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] flag_q, flag_d;
    logic [WIDTH-1:0] accept;

    always_comb begin
        filt_d = filt_q;
        rise_d = '0;
        fall_d = '0;
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                    if (din[i] != filt_q[i]) begin
                        if (LAST == '0) begin
                            accept[i] = 1'b1;
                        end else begin
                            cnt_d[i]   = CW'(1);
                            state_d[i] = PEND;
                        end
                    end
                end
                PEND: begin
                    if (din[i] == filt_q[i]) begin
                        // glitch: fell back before acceptance, nothing reported
                        cnt_d[i]   = '0;
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == LAST) begin
                        accept[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    cnt_d[i]   = '0;
                    state_d[i] = IDLE;
                end
            endcase
            if (accept[i]) begin
                filt_d[i]  = din[i];
                rise_d[i]  = din[i];
                fall_d[i]  = ~din[i];
                cnt_d[i]   = '0;
                state_d[i] = IDLE;
            end
        end
        // a new acceptance beats a clear arriving in the same cycle
        flag_d = accept | (flag_q & ~evt_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= INIT_VAL;
            rise_q <= '0;
            fall_q <= '0;
            flag_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            flag_q <= flag_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign filt_out = filt_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign evt_flag = flag_q;

`ifdef UTIL_SYNC_FILTER_CNT_EN
    localparam int SW = CNT_W + $clog2(WIDTH + 1);

    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic [SW-1:0]    cnt_sum;

    // counts acceptances in the same cycle their pulses appear on rise/fall
    always_comb begin
        cnt_sum = SW'(evt_cnt_q);
        for (int i = 0; i < WIDTH; i++) begin
            cnt_sum = cnt_sum + SW'(rise_d[i] | fall_d[i]);
        end
        if (cnt_sum > SW'({CNT_W{1'b1}})) begin
            evt_cnt_d = '1;
        end else begin
            evt_cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_cnt = evt_cnt_q;
`else
    assign evt_cnt = '0;
`endif

endmodule
